// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory slice.
//   size_e  : access size encodings carried on the 2-bit size port
//   fault_e : fault codes reported on fault_code
//   lane_mask() : byte-lane enable mask for a given size and byte lane
package data_memory_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10,
      FAULT_SIZE     = 2'b11
   } fault_e;

   // Half accesses use the lane pair selected by lane[1]; the lane[0] bit
   // of a half access is rejected as misaligned before this mask is used.
   function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] lane);
      case (sz)
         SIZE_BYTE: return 4'b0001 << lane;
         SIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: return 4'b1111;
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_sized_load_aligner.sv
// Combinational load aligner: picks the addressed byte/half/word out of a
// raw little-endian storage word, shifts it to bit 0 and sign- or
// zero-extends it.
//   raw           : full storage word
//   lane          : byte lane (address[1:0])
//   size          : access size
//   unsigned_load : 1 = zero-extend, 0 = sign-extend sub-word results
//   data          : aligned, extended result (0 for the illegal size)
module load_aligner
   import data_memory_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [1:0]  lane,
   input  size_e       size,
   input  logic        unsigned_load,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic        sbit;

   always_comb begin
      shifted = raw >> {lane, 3'b000};
      sbit    = 1'b0;
      data    = '0;
      case (size)
         SIZE_BYTE: begin
            sbit = ~unsigned_load & shifted[7];
            data = {{24{sbit}}, shifted[7:0]};
         end
         SIZE_HALF: begin
            sbit = ~unsigned_load & shifted[15];
            data = {{16{sbit}}, shifted[15:0]};
         end
         // legal word accesses always have lane 0, so shifted equals raw
         SIZE_WORD: data = shifted;
         default:   data = '0;
      endcase
   end

endmodule

// File: rtl/data_memory_sized.sv
// Parametrised data memory with byte/half/word little-endian access,
// access-error detection and a READ_LATENCY-deep registered read path.
//   clock, reset_n   : rising-edge clock, asynchronous active-low reset
//   memwrite/memread : store / load request this cycle
//   size             : 00 byte, 01 half, 10 word, 11 illegal
//   unsigned_load    : zero-extend sub-word loads when set
//   address          : byte address
//   writedata        : store data, sub-word stores use the low bits
//   readdata         : aligned, extended load result
//   readvalid        : one-cycle strobe per accepted load
//   fault/fault_code : error status of the access producing this output
module data_memory_sized
   import data_memory_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DEPTH_WORDS  = 256,
   parameter int unsigned READ_LATENCY = 1
)(
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  memwrite,
   input  logic                  memread,
   input  logic [1:0]            size,
   input  logic                  unsigned_load,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] writedata,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  readvalid,
   output logic                  fault,
   output logic [1:0]            fault_code
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   size_e                 sz;
   logic [IDX_W-1:0]      idx;
   logic [1:0]            lane;
   logic                  out_of_range;
   fault_e                err;
   logic [3:0]            wmask;
   logic [DATA_WIDTH-1:0] bitmask;
   logic [DATA_WIDTH-1:0] wdata_lanes;
   logic [DATA_WIDTH-1:0] raw;
   logic [DATA_WIDTH-1:0] aligned;

   assign sz   = size_e'(size);
   assign idx  = address[IDX_W+1:2];
   assign lane = address[1:0];

   if (ADDR_WIDTH > IDX_W + 2) begin : g_range
      assign out_of_range = |address[ADDR_WIDTH-1:IDX_W+2];
   end else begin : g_norange
      assign out_of_range = 1'b0;
   end

   always_comb begin
      err = FAULT_NONE;
      if (sz == SIZE_ILLEGAL)
         err = FAULT_SIZE;
      else if ((sz == SIZE_HALF && lane[0]) || (sz == SIZE_WORD && lane != 2'b00))
         err = FAULT_MISALIGN;
      else if (out_of_range)
         err = FAULT_RANGE;
   end

   // Store data is replicated across lanes so the lane mask alone picks
   // where it lands.
   always_comb begin
      wmask       = lane_mask(sz, lane);
      bitmask     = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
      wdata_lanes = '0;
      case (sz)
         SIZE_BYTE: wdata_lanes = {4{writedata[7:0]}};
         SIZE_HALF: wdata_lanes = {2{writedata[15:0]}};
         SIZE_WORD: wdata_lanes = writedata;
         default:   wdata_lanes = '0;
      endcase
   end

   // Read-modify-write of the whole word keeps storage in a single process;
   // the combinational read below sees the pre-store contents.
   assign raw = mem[idx];

   always_ff @(posedge clock) begin
      if (memwrite && err == FAULT_NONE)
         mem[idx] <= (raw & ~bitmask) | (wdata_lanes & bitmask);
   end

   load_aligner u_align (
      .raw           (raw),
      .lane          (lane),
      .size          (sz),
      .unsigned_load (unsigned_load),
      .data          (aligned)
   );

   logic                  pv [READ_LATENCY];
   logic [DATA_WIDTH-1:0] pd [READ_LATENCY];
   fault_e                pc [READ_LATENCY];
   fault_e                scode;

   for (genvar s = 0; s < READ_LATENCY; s++) begin : g_pipe
      if (s == 0) begin : g_first
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pv[0] <= 1'b0;
               pd[0] <= '0;
               pc[0] <= FAULT_NONE;
            end else begin
               pv[0] <= memread;
               pd[0] <= (memread && err == FAULT_NONE) ? aligned : '0;
               pc[0] <= memread ? err : FAULT_NONE;
            end
         end
      end else begin : g_next
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pv[s] <= 1'b0;
               pd[s] <= '0;
               pc[s] <= FAULT_NONE;
            end else begin
               pv[s] <= pv[s-1];
               pd[s] <= pd[s-1];
               pc[s] <= pc[s-1];
            end
         end
      end
   end

   // One-cycle store-fault pulse, independent of the read pipeline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         scode <= FAULT_NONE;
      else
         scode <= memwrite ? err : FAULT_NONE;
   end

   // A load result emerging in the same cycle as a store-fault pulse takes
   // precedence on fault/fault_code.
   assign readvalid  = pv[READ_LATENCY-1];
   assign readdata   = pd[READ_LATENCY-1];
   assign fault_code = pv[READ_LATENCY-1] ? pc[READ_LATENCY-1] : scode;
   assign fault      = (fault_code != FAULT_NONE);

endmodule

// File: tb/tb_data_memory_sized.sv
module tb_data_memory_sized;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        memwrite;
   logic        memread;
   logic [1:0]  size;
   logic        unsigned_load;
   logic [31:0] address;
   logic [31:0] writedata;

   logic [31:0] rd1, rd3;
   logic        rv1, rv3, f1, f3;
   logic [1:0]  fc1, fc3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   data_memory_sized #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(1)) u1 (
      .clock(clock), .reset_n(reset_n), .memwrite(memwrite), .memread(memread),
      .size(size), .unsigned_load(unsigned_load), .address(address), .writedata(writedata),
      .readdata(rd1), .readvalid(rv1), .fault(f1), .fault_code(fc1)
   );

   data_memory_sized #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(256), .READ_LATENCY(3)) u3 (
      .clock(clock), .reset_n(reset_n), .memwrite(memwrite), .memread(memread),
      .size(size), .unsigned_load(unsigned_load), .address(address), .writedata(writedata),
      .readdata(rd3), .readvalid(rv3), .fault(f3), .fault_code(fc3)
   );

   typedef struct {
      logic        w;
      logic        r;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        ev;
      logic [31:0] ed;
      logic [1:0]  ec;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
      @(negedge clock);
      memwrite      = w;
      memread       = r;
      size          = sz;
      unsigned_load = u;
      address       = a;
      writedata     = wd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk1(input string nm, input logic ev, input logic [31:0] ed, input logic [1:0] ec);
      chk({nm, " rv1"}, {31'b0, rv1}, {31'b0, ev});
      chk({nm, " rd1"}, rd1, ed);
      chk({nm, " fault1"}, {31'b0, f1}, {31'b0, (ec != 2'b00)});
      chk({nm, " code1"}, {30'b0, fc1}, {30'b0, ec});
   endtask

   task automatic chk3(input string nm, input logic ev, input logic [31:0] ed, input logic [1:0] ec);
      chk({nm, " rv3"}, {31'b0, rv3}, {31'b0, ev});
      chk({nm, " rd3"}, rd3, ed);
      chk({nm, " fault3"}, {31'b0, f3}, {31'b0, (ec != 2'b00)});
      chk({nm, " code3"}, {30'b0, fc3}, {30'b0, ec});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_d [6];
      logic        exp_v [6];

      reset_n = 1'b0;
      memwrite = 1'b0; memread = 1'b0; size = 2'b00; unsigned_load = 1'b0;
      address = '0; writedata = '0;
      #3;
      chk1("reset", 1'b0, 32'h0, 2'b00);
      chk3("reset", 1'b0, 32'h0, 2'b00);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      //                w  r  sz     u  addr          wd            ev ed            ec
      vq.push_back(vec_t'{1, 0, 2'b10, 0, 32'h8,        32'hDEADBEEF, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h8,        32'h0,        1, 32'hDEADBEEF, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b10, 0, 32'h4,        32'h123480F0, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{0, 1, 2'b00, 0, 32'h4,        32'h0,        1, 32'hFFFFFFF0, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b00, 1, 32'h4,        32'h0,        1, 32'h000000F0, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b01, 0, 32'h6,        32'h0,        1, 32'h00001234, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b01, 0, 32'h4,        32'h0,        1, 32'hFFFF80F0, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b01, 1, 32'h4,        32'h0,        1, 32'h000080F0, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b00, 0, 32'h7,        32'h0,        1, 32'h00000012, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b00, 0, 32'h5,        32'h0,        1, 32'hFFFFFF80, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b10, 0, 32'h0,        32'hAAAABBBB, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{1, 0, 2'b00, 0, 32'h2,        32'hFFFFFF55, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h0,        32'h0,        1, 32'hAA55BBBB, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b01, 0, 32'h2,        32'h0000CAFE, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h0,        32'h0,        1, 32'hCAFEBBBB, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b10, 0, 32'h5,        32'h11111111, 0, 32'h0,        2'b01});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h4,        32'h0,        1, 32'h123480F0, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h400,      32'h0,        1, 32'h0,        2'b10});
      vq.push_back(vec_t'{0, 1, 2'b11, 0, 32'h0,        32'h0,        1, 32'h0,        2'b11});
      vq.push_back(vec_t'{0, 1, 2'b01, 0, 32'h3,        32'h0,        1, 32'h0,        2'b01});
      vq.push_back(vec_t'{0, 1, 2'b11, 0, 32'h401,      32'h0,        1, 32'h0,        2'b11});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h402,      32'h0,        1, 32'h0,        2'b01});
      vq.push_back(vec_t'{0, 0, 2'b00, 0, 32'h0,        32'h0,        0, 32'h0,        2'b00});
      vq.push_back(vec_t'{1, 0, 2'b11, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        2'b11});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h0,        32'h0,        1, 32'hCAFEBBBB, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b10, 0, 32'h3FC,      32'h0BADF00D, 0, 32'h0,        2'b00});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h3FC,      32'h0,        1, 32'h0BADF00D, 2'b00});
      vq.push_back(vec_t'{0, 1, 2'b01, 1, 32'h3FE,      32'h0,        1, 32'h00000BAD, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b01, 0, 32'h1,        32'h0,        0, 32'h0,        2'b01});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h0,        32'h0,        1, 32'hCAFEBBBB, 2'b00});
      vq.push_back(vec_t'{1, 0, 2'b00, 0, 32'h80000000, 32'h00000077, 0, 32'h0,        2'b10});
      vq.push_back(vec_t'{0, 1, 2'b10, 0, 32'h0,        32'h0,        1, 32'hCAFEBBBB, 2'b00});

      foreach (vq[i]) begin
         drive(vq[i].w, vq[i].r, vq[i].sz, vq[i].u, vq[i].addr, vq[i].wd);
         step();
         chk1($sformatf("vec%0d", i), vq[i].ev, vq[i].ed, vq[i].ec);
      end

      // Back-to-back loads through the 3-deep pipeline.
      idle();
      repeat (4) step();
      exp_v = '{0, 0, 1, 1, 1, 0};
      exp_d = '{32'h0, 32'h0, 32'hCAFEBBBB, 32'h123480F0, 32'hDEADBEEF, 32'h0};
      for (int k = 0; k < 6; k++) begin
         if (k < 3) drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * k), 32'h0);
         else       idle();
         step();
         chk3($sformatf("pipe%0d", k), exp_v[k], exp_d[k], 2'b00);
      end

      // Simultaneous load and store to the same word returns the old value.
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h77777777);
      step();
      drive(1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'h99999999);
      step();
      chk1("coll", 1'b1, 32'h77777777, 2'b00);
      chk3("coll_e1", 1'b0, 32'h0, 2'b00);
      idle();
      step();
      chk3("coll_e2", 1'b0, 32'h0, 2'b00);
      step();
      chk3("coll_e3", 1'b1, 32'h77777777, 2'b00);
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'hC, 32'h0);
      step();
      chk1("after_coll", 1'b1, 32'h99999999, 2'b00);
      idle();
      step();
      step();
      chk3("after_coll", 1'b1, 32'h99999999, 2'b00);

      // Reset asserted while a load is in flight.
      idle();
      repeat (3) step();
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
      step();
      chk1("pre_rst", 1'b1, 32'hDEADBEEF, 2'b00);
      idle();
      reset_n = 1'b0;
      #1;
      chk3("in_rst", 1'b0, 32'h0, 2'b00);
      chk1("in_rst", 1'b0, 32'h0, 2'b00);
      step();
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk3($sformatf("post_rst%0d", k), 1'b0, 32'h0, 2'b00);
      end
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0);
      step();
      chk1("reload", 1'b1, 32'hDEADBEEF, 2'b00);
      idle();
      step();
      chk3("reload_e2", 1'b0, 32'h0, 2'b00);
      step();
      chk3("reload_e3", 1'b1, 32'hDEADBEEF, 2'b00);
      step();
      chk3("reload_e4", 1'b0, 32'h0, 2'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
